sobel_window_sequencer: RTL and testbench

Sequences the Sobel gradient datapath. Accepts a raster-order pixel stream and buffers two previous lines. Presents each valid 3x3 neighbourhood as P0..P8 with a start_calculations strobe to the horizontal/vertical gradient units. Sits between the frame reader and the gradient/magnitude stage, and tracks frame progress and border suppression.

---
 rtl/sobel_pkg.sv | 18 +
 rtl/sobel_line_buffer.sv | 27 ++
 rtl/sobel_window_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_sobel_window_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel window sequencer slice.
// Frame geometry defaults match the VGA-sized frame reader upstream.
package sobel_pkg;

    localparam int unsigned IMG_WIDTH_DEF  = 640;
    localparam int unsigned IMG_HEIGHT_DEF = 480;
    localparam int unsigned PIX_W_DEF      = 8;

    typedef logic [PIX_W_DEF-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } seq_state_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// One line of pixel storage with a combinational read of the entry about to be
// overwritten, so a single address yields the old value and stores the new one.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int unsigned DEPTH = IMG_WIDTH_DEF,
    parameter int unsigned WIDTH = PIX_W_DEF
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sobel_window_sequencer.sv
// Turns a raster pixel stream into 3x3 neighbourhoods for the gradient units,
// with border suppression, backpressure from the consumer and frame tracking.
module sobel_window_sequencer
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int unsigned PIX_W      = PIX_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_start,
    input  logic [PIX_W-1:0]              pix_data,
    input  logic                          pix_valid,
    output logic                          pix_ready,
    output logic [PIX_W-1:0]              P0,
    output logic [PIX_W-1:0]              P1,
    output logic [PIX_W-1:0]              P2,
    output logic [PIX_W-1:0]              P3,
    output logic [PIX_W-1:0]              P4,
    output logic [PIX_W-1:0]              P5,
    output logic [PIX_W-1:0]              P6,
    output logic [PIX_W-1:0]              P7,
    output logic [PIX_W-1:0]              P8,
    output logic                          start_calculations,
    input  logic                          win_ready,
    output logic [$clog2(IMG_WIDTH)-1:0]  center_x,
    output logic [$clog2(IMG_HEIGHT)-1:0] center_y,
    output logic                          busy,
    output logic                          frame_done
);

    localparam int unsigned XW = $clog2(IMG_WIDTH);
    localparam int unsigned YW = $clog2(IMG_HEIGHT);

    localparam logic [XW-1:0] COL_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] ROW_LAST = YW'(IMG_HEIGHT - 1);
    localparam logic [XW-1:0] COL_TWO  = XW'(2);
    localparam logic [YW-1:0] ROW_ONE  = YW'(1);
    localparam logic [YW-1:0] ROW_TWO  = YW'(2);

    seq_state_t state_q, state_d;
    logic [XW-1:0] col_q, col_d;
    logic [YW-1:0] row_q, row_d;
    logic [XW-1:0] cx_q, cx_d;
    logic [YW-1:0] cy_q, cy_d;
    logic          start_q, start_d;
    logic          done_q, done_d;
    logic [PIX_W-1:0] win_q [9];
    logic [PIX_W-1:0] win_d [9];

    logic [PIX_W-1:0] lb0_rd;
    logic [PIX_W-1:0] lb1_rd;
    logic             accept;
    logic             consume;
    logic             col_wrap;
    logic             emit;

    assign busy      = (state_q == FILL) || (state_q == RUN);
    assign pix_ready = busy && !(start_q && !win_ready);
    assign accept    = pix_valid && pix_ready;
    assign consume   = start_q && win_ready;
    assign col_wrap  = (col_q == COL_LAST);
    assign emit      = (row_q >= ROW_TWO) && (col_q >= COL_TWO);

    // lb0 holds row y-1, lb1 holds row y-2; lb1 is fed from lb0's pre-write value.
    sobel_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (PIX_W)
    ) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (col_q),
        .wdata (pix_data),
        .rdata (lb0_rd)
    );

    sobel_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (PIX_W)
    ) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (col_q),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        start_d = start_q;
        done_d  = 1'b0;
        win_d   = win_q;

        if (consume) begin
            start_d = 1'b0;
        end

        if (accept) begin
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = lb1_rd;
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = lb0_rd;
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = pix_data;

            // Columns 0 and 1 of each line only prime the window, so the stale
            // columns left over from the previous line never reach the output.
            if (emit) begin
                start_d = 1'b1;
                cx_d    = col_q - 1'b1;
                cy_d    = row_q - 1'b1;
            end

            if (col_wrap) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = FILL;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            FILL: begin
                if (accept && col_wrap && (row_q == ROW_ONE)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept && col_wrap && (row_q == ROW_LAST)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (consume) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            win_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            start_q <= start_d;
            done_q  <= done_d;
            win_q   <= win_d;
        end
    end

    assign P0 = win_q[0];
    assign P1 = win_q[1];
    assign P2 = win_q[2];
    assign P3 = win_q[3];
    assign P4 = win_q[4];
    assign P5 = win_q[5];
    assign P6 = win_q[6];
    assign P7 = win_q[7];
    assign P8 = win_q[8];

    assign start_calculations = start_q;
    assign center_x           = cx_q;
    assign center_y           = cy_q;
    assign frame_done         = done_q;

endmodule

// File: tb/tb_sobel_window_sequencer.sv
// Scoreboard bench for the Sobel window sequencer on a 4x4 frame.
module tb_sobel_window_sequencer;
    import sobel_pkg::*;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_start;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] P0, P1, P2, P3, P4, P5, P6, P7, P8;
    logic       start_calculations;
    logic       win_ready;
    logic [1:0] center_x;
    logic [1:0] center_y;
    logic       busy;
    logic       frame_done;

    pixel_t       img [H][W];
    logic [127:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int win_cnt = 0;
    int fd_cnt = 0;
    int stall_cycles = 0;

    sobel_window_sequencer #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .PIX_W      (8)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .frame_start        (frame_start),
        .pix_data           (pix_data),
        .pix_valid          (pix_valid),
        .pix_ready          (pix_ready),
        .P0                 (P0),
        .P1                 (P1),
        .P2                 (P2),
        .P3                 (P3),
        .P4                 (P4),
        .P5                 (P5),
        .P6                 (P6),
        .P7                 (P7),
        .P8                 (P8),
        .start_calculations (start_calculations),
        .win_ready          (win_ready),
        .center_x           (center_x),
        .center_y           (center_y),
        .busy               (busy),
        .frame_done         (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pack_win(
        input pixel_t a0, input pixel_t a1, input pixel_t a2,
        input pixel_t a3, input pixel_t a4, input pixel_t a5,
        input pixel_t a6, input pixel_t a7, input pixel_t a8,
        input logic [1:0] cx, input logic [1:0] cy);
        return {52'b0, a0, a1, a2, a3, a4, a5, a6, a7, a8, cx, cy};
    endfunction

    function automatic logic [127:0] dut_win();
        return pack_win(P0, P1, P2, P3, P4, P5, P6, P7, P8, center_x, center_y);
    endfunction

    function automatic logic [127:0] dut_all();
        return {dut_win(), start_calculations, busy, frame_done, pix_ready};
    endfunction

    // Consumer: stalls the first window of a frame for stall_cycles cycles.
    initial begin
        int used = 0;
        win_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!busy && !start_calculations) used = 0;
            if (start_calculations && used < stall_cycles) begin
                win_ready = 1'b0;
                used++;
            end else begin
                win_ready = 1'b1;
            end
        end
    end

    // Monitor: compares consumed windows and checks stability during stalls.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (start_calculations) begin
                    if (exp_q.size() == 0) begin
                        check("win_unexpected", 128'(start_calculations), 128'(0));
                    end else if (win_ready) begin
                        check("window", dut_win(), exp_q.pop_front());
                        win_cnt++;
                    end else begin
                        check("stall_hold", dut_win(), exp_q[0]);
                        check("stall_rdy", 128'(pix_ready), 128'(0));
                    end
                end
                if (frame_done) fd_cnt++;
            end
        end
    end

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic send_pixel(input int r, input int c);
        int n = 0;
        pix_data  = img[r][c];
        pix_valid = 1'b1;
        @(negedge clk);
        while (!pix_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!pix_ready) begin
            check("pix_accept", 128'(pix_ready), 128'(1));
            pix_valid = 1'b0;
            return;
        end
        if (r >= 2 && c >= 2) begin
            exp_q.push_back(pack_win(
                img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                img[r][c-2],   img[r][c-1],   img[r][c],
                2'(c - 1), 2'(r - 1)));
        end
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        check("start_lat", 128'(start_calculations), 128'(r >= 2 && c >= 2));
    endtask

    task automatic fill_img(input bit rnd);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                img[r][c] = rnd ? pixel_t'($urandom_range(0, 255)) : pixel_t'(r * W + c);
            end
        end
    endtask

    task automatic run_frame(input int gap, input int fs_at, input bit rnd);
        int win0;
        int fd0;
        int n = 0;
        fill_img(rnd);
        win0 = win_cnt;
        fd0  = fd_cnt;
        pulse_frame_start();
        for (int i = 0; i < W * H; i++) begin
            if (i == fs_at) pulse_frame_start();
            send_pixel(i / W, i % W);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        while (fd_cnt == fd0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("frame_done_seen", 128'(fd_cnt != fd0), 128'(1));
        repeat (4) @(posedge clk);
        #1;
        check("frame_done_cnt", 128'(fd_cnt - fd0), 128'(1));
        check("win_cnt", 128'(win_cnt - win0), 128'(4));
        check("idle_busy", 128'(busy), 128'(0));
        check("q_empty", 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        pix_data    = '0;
        pix_valid   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", dut_all(), 128'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        stall_cycles = 0;
        run_frame(0, -1, 1'b0);

        stall_cycles = 3;
        run_frame(0, -1, 1'b0);
        stall_cycles = 0;

        run_frame(1, -1, 1'b0);
        run_frame(0, -1, 1'b1);

        // Reset mid-frame after ten pixels, then a clean frame.
        fill_img(1'b0);
        pulse_frame_start();
        for (int i = 0; i < 10; i++) send_pixel(i / W, i % W);
        rst = 1'b1;
        #1;
        check("midframe_reset", dut_all(), 128'(0));
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_frame(0, -1, 1'b0);

        run_frame(0, 12, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
